// File: rtl/edlo_pkg.sv
// Shared opcodes, FSM state encoding and helpers for the EDLO execution unit.
// Optional multiply is enabled by defining EDLO_MUL_EN.
package edlo_pkg;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_LDI  = 4'h1;
    localparam logic [3:0] OP_LD   = 4'h2;
    localparam logic [3:0] OP_ST   = 4'h3;
    localparam logic [3:0] OP_ADD  = 4'h4;
    localparam logic [3:0] OP_SUB  = 4'h5;
    localparam logic [3:0] OP_AND  = 4'h6;
    localparam logic [3:0] OP_OR   = 4'h7;
    localparam logic [3:0] OP_XOR  = 4'h8;
    localparam logic [3:0] OP_SHL  = 4'h9;
    localparam logic [3:0] OP_SHR  = 4'hA;
    localparam logic [3:0] OP_ADDI = 4'hB;
    localparam logic [3:0] OP_MUL  = 4'hC;
    localparam logic [3:0] OP_OUT  = 4'hD;
    localparam logic [3:0] OP_CLRM = 4'hE;
    localparam logic [3:0] OP_ILL  = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_CLRM = 2'd2
    } state_t;

    // Larger of two sizes, used to size the shared step counter.
    function automatic int unsigned edlo_max(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/edlo_regfile.sv
// Scratch RAM: one synchronous write port, one asynchronous read port.
// Not reset; a write is visible to the read port on the following cycle.
module edlo_regfile #(
    parameter int unsigned DW    = 8,
    parameter int unsigned DEPTH = 16,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];

    // Write port
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/edlo_exec_unit.sv
// EDLO execution unit: accumulator ALU, scratch RAM, valid/ready instruction port,
// multi-cycle memory clear and (with EDLO_MUL_EN defined) shift-add multiply.
module edlo_exec_unit
    import edlo_pkg::*;
#(
    parameter int unsigned DW    = 8,
    parameter int unsigned DEPTH = 16,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          inst_valid,
    output logic          inst_ready,
    input  logic [3:0]    opcode,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] data_in,
    output logic [DW-1:0] data_out,
    output logic [DW-1:0] acc,
    output logic          flag_z,
    output logic          flag_c,
    output logic          flag_err
);

    localparam int unsigned CW = $clog2(edlo_max(DW, DEPTH)) + 1;

    state_t        state_q, state_nxt;
    logic [CW-1:0] cnt_q, cnt_nxt;
    logic [DW-1:0] acc_q, acc_nxt;
    logic [DW-1:0] dout_q, dout_nxt;
    logic          z_q, z_nxt;
    logic          c_q, c_nxt;
    logic          err_q, err_nxt;
    logic          ready_q, ready_nxt;

    logic          xfer;
    logic          illegal;
    logic          we_c;
    logic [AW-1:0] waddr_c;
    logic [DW-1:0] wdata_c;
    logic [DW-1:0] mem_rdata;

    logic [DW:0]   alu_wide;
    logic [DW-1:0] alu_res;
    logic          alu_c;
    logic          alu_upd;

`ifdef EDLO_MUL_EN
    logic [2*DW-1:0] prod_q, prod_nxt;
    logic [2*DW-1:0] mcand_q, mcand_nxt;
    logic [DW-1:0]   mplier_q, mplier_nxt;
    logic [2*DW-1:0] prod_step;
`endif

    assign xfer = inst_valid & ready_q;

`ifdef EDLO_MUL_EN
    assign illegal = (opcode == OP_ILL);
`else
    assign illegal = (opcode == OP_ILL) || (opcode == OP_MUL);
`endif

    edlo_regfile #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_regfile (
        .clk   (clk),
        .we    (we_c & rst_n),
        .waddr (waddr_c),
        .wdata (wdata_c),
        .raddr (addr),
        .rdata (mem_rdata)
    );

    // Single-cycle ALU: result, carry and whether acc/flag_z are written
    always_comb begin
        alu_wide = '0;
        alu_res  = acc_q;
        alu_c    = c_q;
        alu_upd  = 1'b0;
        case (opcode)
            OP_LDI: begin
                alu_res = data_in;
                alu_upd = 1'b1;
            end
            OP_LD: begin
                alu_res = mem_rdata;
                alu_upd = 1'b1;
            end
            OP_ADD: begin
                alu_wide = {1'b0, acc_q} + {1'b0, mem_rdata};
                alu_res  = alu_wide[DW-1:0];
                alu_c    = alu_wide[DW];
                alu_upd  = 1'b1;
            end
            OP_SUB: begin
                alu_wide = {1'b0, acc_q} - {1'b0, mem_rdata};
                alu_res  = alu_wide[DW-1:0];
                alu_c    = alu_wide[DW];
                alu_upd  = 1'b1;
            end
            OP_AND: begin
                alu_res = acc_q & mem_rdata;
                alu_upd = 1'b1;
            end
            OP_OR: begin
                alu_res = acc_q | mem_rdata;
                alu_upd = 1'b1;
            end
            OP_XOR: begin
                alu_res = acc_q ^ mem_rdata;
                alu_upd = 1'b1;
            end
            OP_SHL: begin
                alu_res = {acc_q[DW-2:0], 1'b0};
                alu_c   = acc_q[DW-1];
                alu_upd = 1'b1;
            end
            OP_SHR: begin
                alu_res = {1'b0, acc_q[DW-1:1]};
                alu_c   = acc_q[0];
                alu_upd = 1'b1;
            end
            OP_ADDI: begin
                alu_wide = {1'b0, acc_q} + {1'b0, data_in};
                alu_res  = alu_wide[DW-1:0];
                alu_c    = alu_wide[DW];
                alu_upd  = 1'b1;
            end
            default: ;
        endcase
    end

    // FSM next state, datapath next values and RAM write port
    always_comb begin
        state_nxt = state_q;
        cnt_nxt   = cnt_q;
        acc_nxt   = acc_q;
        dout_nxt  = dout_q;
        z_nxt     = z_q;
        c_nxt     = c_q;
        err_nxt   = err_q;
        we_c      = 1'b0;
        waddr_c   = addr;
        wdata_c   = acc_q;
`ifdef EDLO_MUL_EN
        prod_nxt   = prod_q;
        mcand_nxt  = mcand_q;
        mplier_nxt = mplier_q;
        prod_step  = prod_q + (mplier_q[0] ? mcand_q : '0);
`endif
        case (state_q)
            ST_IDLE: begin
                if (xfer) begin
                    if (alu_upd) begin
                        acc_nxt = alu_res;
                        z_nxt   = (alu_res == '0);
                        c_nxt   = alu_c;
                    end
                    case (opcode)
                        OP_LDI, OP_LD: dout_nxt = alu_res;
                        OP_ST:         we_c     = 1'b1;
                        OP_OUT:        dout_nxt = mem_rdata;
                        OP_CLRM: begin
                            state_nxt = ST_CLRM;
                            cnt_nxt   = '0;
                        end
`ifdef EDLO_MUL_EN
                        OP_MUL: begin
                            state_nxt  = ST_MUL;
                            cnt_nxt    = '0;
                            prod_nxt   = '0;
                            mcand_nxt  = (2*DW)'(mem_rdata);
                            mplier_nxt = acc_q;
                        end
`endif
                        default: ;
                    endcase
                    if (illegal) begin
                        err_nxt = 1'b1;
                    end
                end
            end
            ST_CLRM: begin
                we_c    = 1'b1;
                waddr_c = cnt_q[AW-1:0];
                wdata_c = '0;
                if (cnt_q == CW'(DEPTH - 1)) begin
                    state_nxt = ST_IDLE;
                end else begin
                    cnt_nxt = cnt_q + CW'(1);
                end
            end
`ifdef EDLO_MUL_EN
            ST_MUL: begin
                prod_nxt   = prod_step;
                mcand_nxt  = mcand_q << 1;
                mplier_nxt = mplier_q >> 1;
                if (cnt_q == CW'(DW - 1)) begin
                    state_nxt = ST_IDLE;
                    acc_nxt   = prod_step[DW-1:0];
                    z_nxt     = (prod_step[DW-1:0] == '0);
                    c_nxt     = |prod_step[2*DW-1:DW];
                end else begin
                    cnt_nxt = cnt_q + CW'(1);
                end
            end
`endif
            default: state_nxt = ST_IDLE;
        endcase
        ready_nxt = (state_nxt == ST_IDLE);
    end

    // State and datapath registers, synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            dout_q  <= '0;
            z_q     <= 1'b0;
            c_q     <= 1'b0;
            err_q   <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_nxt;
            cnt_q   <= cnt_nxt;
            acc_q   <= acc_nxt;
            dout_q  <= dout_nxt;
            z_q     <= z_nxt;
            c_q     <= c_nxt;
            err_q   <= err_nxt;
            ready_q <= ready_nxt;
        end
    end

`ifdef EDLO_MUL_EN
    // Multiplier working registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prod_q   <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
        end else begin
            prod_q   <= prod_nxt;
            mcand_q  <= mcand_nxt;
            mplier_q <= mplier_nxt;
        end
    end
`endif

    assign inst_ready = ready_q;
    assign data_out   = dout_q;
    assign acc        = acc_q;
    assign flag_z     = z_q;
    assign flag_c     = c_q;
    assign flag_err   = err_q;

endmodule

// File: tb/tb_edlo_exec_unit.sv
// Self-checking bench for edlo_exec_unit (DW=8, DEPTH=16); follows EDLO_MUL_EN if defined.
module tb_edlo_exec_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       inst_valid;
    logic       inst_ready;
    logic [3:0] opcode;
    logic [3:0] addr;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic [7:0] acc;
    logic       flag_z;
    logic       flag_c;
    logic       flag_err;

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [7:0] m_mem [16];
    logic [7:0] m_acc;
    logic [7:0] m_dout;
    logic       m_z;
    logic       m_c;
    logic       m_err;

    typedef struct {
        logic [3:0] op;
        logic [3:0] a;
        logic [7:0] d;
        logic [7:0] e_acc;
        logic [7:0] e_dout;
        logic       e_z;
        logic       e_c;
        logic       e_err;
    } vec_t;

    vec_t tbl [18];

    always #5 clk = ~clk;

    edlo_exec_unit #(.DW(8), .DEPTH(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .inst_valid (inst_valid),
        .inst_ready (inst_ready),
        .opcode     (opcode),
        .addr       (addr),
        .data_in    (data_in),
        .data_out   (data_out),
        .acc        (acc),
        .flag_z     (flag_z),
        .flag_c     (flag_c),
        .flag_err   (flag_err)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", name, got, exp);
        end
    endtask

    // Instruction semantics in plain arithmetic
    function automatic void model_apply(input int op, input int a, input int d);
        int s;
        case (op)
            1:  begin m_acc = 8'(d); m_dout = m_acc; m_z = (m_acc == 0); end
            2:  begin m_acc = m_mem[a]; m_dout = m_acc; m_z = (m_acc == 0); end
            3:  m_mem[a] = m_acc;
            4:  begin s = int'(m_acc) + int'(m_mem[a]); m_c = (s > 255); m_acc = 8'(s); m_z = (m_acc == 0); end
            5:  begin m_c = (m_acc < m_mem[a]); s = int'(m_acc) - int'(m_mem[a]); m_acc = 8'(s); m_z = (m_acc == 0); end
            6:  begin m_acc = m_acc & m_mem[a]; m_z = (m_acc == 0); end
            7:  begin m_acc = m_acc | m_mem[a]; m_z = (m_acc == 0); end
            8:  begin m_acc = m_acc ^ m_mem[a]; m_z = (m_acc == 0); end
            9:  begin m_c = (m_acc >= 8'd128); s = int'(m_acc) * 2; m_acc = 8'(s); m_z = (m_acc == 0); end
            10: begin m_c = m_acc[0]; m_acc = m_acc / 8'd2; m_z = (m_acc == 0); end
            11: begin s = int'(m_acc) + d; m_c = (s > 255); m_acc = 8'(s); m_z = (m_acc == 0); end
`ifdef EDLO_MUL_EN
            12: begin s = int'(m_acc) * int'(m_mem[a]); m_c = (s > 255); m_acc = 8'(s); m_z = (m_acc == 0); end
`else
            12: m_err = 1'b1;
`endif
            13: m_dout = m_mem[a];
            14: for (int i = 0; i < 16; i++) m_mem[i] = 8'h00;
            15: m_err = 1'b1;
            default: ;
        endcase
    endfunction

    task automatic compare_all(input string tag);
        check($sformatf("%s acc", tag), 32'(acc), 32'(m_acc));
        check($sformatf("%s data_out", tag), 32'(data_out), 32'(m_dout));
        check($sformatf("%s flag_z", tag), 32'(flag_z), 32'(m_z));
        check($sformatf("%s flag_c", tag), 32'(flag_c), 32'(m_c));
        check($sformatf("%s flag_err", tag), 32'(flag_err), 32'(m_err));
    endtask

    // Called at a negedge; returns at the negedge after the transfer edge
    task automatic issue(input logic [3:0] op, input logic [3:0] a, input logic [7:0] d);
        int guard;
        guard      = 0;
        inst_valid = 1'b1;
        opcode     = op;
        addr       = a;
        data_in    = d;
        while (!inst_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        total++;
        if (!inst_ready) begin
            bad++;
            $display("FAIL issue_timeout: ready=%0b want=1", inst_ready);
        end
        @(posedge clk);
        @(negedge clk);
        inst_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int guard;
        guard = 0;
        while (!inst_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        total++;
        if (!inst_ready) begin
            bad++;
            $display("FAIL idle_timeout: ready=%0b want=1", inst_ready);
        end
    endtask

    // Issue a multi-cycle op holding valid high; count cycles with ready low
    task automatic busy_op(input logic [3:0] op, input logic [3:0] a, output int n);
        n = 0;
        wait_idle();
        inst_valid = 1'b1;
        opcode     = op;
        addr       = a;
        data_in    = 8'h00;
        @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 100; k++) begin
            if (inst_ready) break;
            n++;
            @(negedge clk);
        end
        inst_valid = 1'b0;
    endtask

    task automatic run(input logic [3:0] op, input logic [3:0] a, input logic [7:0] d, input string tag);
        issue(op, a, d);
        wait_idle();
        model_apply(int'(op), int'(a), int'(d));
        compare_all(tag);
    endtask

    initial begin
        int n;
        int op;

        tbl[0]  = '{4'h1, 4'h0, 8'hF0, 8'hF0, 8'hF0, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{4'h3, 4'h3, 8'h00, 8'hF0, 8'hF0, 1'b0, 1'b0, 1'b0};
        tbl[2]  = '{4'h1, 4'h0, 8'h20, 8'h20, 8'h20, 1'b0, 1'b0, 1'b0};
        tbl[3]  = '{4'h4, 4'h3, 8'h00, 8'h10, 8'h20, 1'b0, 1'b1, 1'b0};
        tbl[4]  = '{4'h5, 4'h3, 8'h00, 8'h20, 8'h20, 1'b0, 1'b1, 1'b0};
        tbl[5]  = '{4'h1, 4'h0, 8'h81, 8'h81, 8'h81, 1'b0, 1'b1, 1'b0};
        tbl[6]  = '{4'h9, 4'h0, 8'h00, 8'h02, 8'h81, 1'b0, 1'b1, 1'b0};
        tbl[7]  = '{4'hA, 4'h0, 8'h00, 8'h01, 8'h81, 1'b0, 1'b0, 1'b0};
        tbl[8]  = '{4'h3, 4'h5, 8'h00, 8'h01, 8'h81, 1'b0, 1'b0, 1'b0};
        tbl[9]  = '{4'h8, 4'h5, 8'h00, 8'h00, 8'h81, 1'b1, 1'b0, 1'b0};
        tbl[10] = '{4'hB, 4'h0, 8'hFF, 8'hFF, 8'h81, 1'b0, 1'b0, 1'b0};
        tbl[11] = '{4'hB, 4'h0, 8'h01, 8'h00, 8'h81, 1'b1, 1'b1, 1'b0};
        tbl[12] = '{4'h7, 4'h3, 8'h00, 8'hF0, 8'h81, 1'b0, 1'b1, 1'b0};
        tbl[13] = '{4'h6, 4'h5, 8'h00, 8'h00, 8'h81, 1'b1, 1'b1, 1'b0};
        tbl[14] = '{4'h1, 4'h0, 8'h00, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0};
        tbl[15] = '{4'hD, 4'h3, 8'h00, 8'h00, 8'hF0, 1'b1, 1'b1, 1'b0};
        tbl[16] = '{4'h0, 4'h0, 8'h00, 8'h00, 8'hF0, 1'b1, 1'b1, 1'b0};
        tbl[17] = '{4'hF, 4'h0, 8'h00, 8'h00, 8'hF0, 1'b1, 1'b1, 1'b1};

        // Reset
        rst_n      = 1'b0;
        inst_valid = 1'b0;
        opcode     = 4'h0;
        addr       = 4'h0;
        data_in    = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        m_acc = 8'h00; m_dout = 8'h00; m_z = 1'b0; m_c = 1'b0; m_err = 1'b0;
        for (int i = 0; i < 16; i++) m_mem[i] = 8'h00;
        compare_all("reset");
        @(negedge clk);
        check("reset ready", 32'(inst_ready), 32'd1);

        // Directed table
        for (int i = 0; i < 18; i++) begin
            issue(tbl[i].op, tbl[i].a, tbl[i].d);
            model_apply(int'(tbl[i].op), int'(tbl[i].a), int'(tbl[i].d));
            check($sformatf("vec%0d acc", i), 32'(acc), 32'(tbl[i].e_acc));
            check($sformatf("vec%0d data_out", i), 32'(data_out), 32'(tbl[i].e_dout));
            check($sformatf("vec%0d flag_z", i), 32'(flag_z), 32'(tbl[i].e_z));
            check($sformatf("vec%0d flag_c", i), 32'(flag_c), 32'(tbl[i].e_c));
            check($sformatf("vec%0d flag_err", i), 32'(flag_err), 32'(tbl[i].e_err));
        end

        // Memory clear with valid held high
        busy_op(4'hE, 4'h0, n);
        check("clrm busy cycles", 32'(n), 32'd16);
        model_apply(14, 0, 0);
        compare_all("clrm");
        for (int i = 0; i < 16; i++) begin
            run(4'hD, 4'(i), 8'h00, $sformatf("out%0d", i));
        end

`ifdef EDLO_MUL_EN
        // Multiply
        run(4'h1, 4'h0, 8'h0B, "mul ldi0");
        run(4'h3, 4'h1, 8'h00, "mul st1");
        run(4'h1, 4'h0, 8'h0C, "mul ldi1");
        busy_op(4'hC, 4'h1, n);
        check("mul busy cycles", 32'(n), 32'd8);
        model_apply(12, 1, 0);
        check("mul1 acc", 32'(acc), 32'h84);
        compare_all("mul1");
        run(4'h1, 4'h0, 8'h10, "mul ldi2");
        run(4'h3, 4'h2, 8'h00, "mul st2");
        run(4'hC, 4'h2, 8'h00, "mul2");
        check("mul2 acc", 32'(acc), 32'h00);
        check("mul2 c", 32'(flag_c), 32'd1);
`endif

        // Randomised instructions against the model
        for (int i = 0; i < 300; i++) begin
            op = int'($urandom_range(0, 15));
            if (op == 14 && $urandom_range(0, 3) != 0) op = 0;
            run(4'(op), 4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)), $sformatf("rnd%0d", i));
        end

        // Reset in the middle of a memory clear
        run(4'h1, 4'h0, 8'h5A, "pre ldi");
        run(4'h3, 4'hF, 8'h00, "pre st");
        issue(4'hE, 4'h0, 8'h00);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        m_acc = 8'h00; m_dout = 8'h00; m_z = 1'b0; m_c = 1'b0; m_err = 1'b0;
        m_mem[0] = 8'h00;
        compare_all("abort");
        @(negedge clk);
        check("abort ready", 32'(inst_ready), 32'd1);
        run(4'hD, 4'hF, 8'h00, "abort keep");
        check("abort keep value", 32'(data_out), 32'h5A);
        run(4'hD, 4'h0, 8'h00, "abort cleared");

        // Opcode C: illegal without the multiplier, product with it
        run(4'h1, 4'h0, 8'h37, "c ldi");
        run(4'hC, 4'h0, 8'h00, "op c");
        run(4'hF, 4'h0, 8'h00, "op f");
        check("op f err", 32'(flag_err), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
